// File: rtl/serial_sub_n.sv
// serial_sub_n: multi-cycle subtractor computing a - b - bin DIGIT bits per clock, LSB first
module serial_sub_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_bout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_d;
    logic             w_brw;
    logic             w_msb_brw;
    logic             w_last;
    logic             w_accept;

    // Current digit slice, its difference, and the borrow that entered its top bit (a^b^d recovers it)
    always_comb begin
        w_a_sh    = r_a >> (int'(r_cnt) * DIGIT);
        w_b_sh    = r_b >> (int'(r_cnt) * DIGIT);
        w_a_dig   = w_a_sh[DIGIT-1:0];
        w_b_dig   = w_b_sh[DIGIT-1:0];
        {w_brw, w_d} = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, r_brw};
        w_msb_brw = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_d[DIGIT-1];
        w_last    = (r_cnt == CW'(N - 1));
        w_accept  = start && (r_state != RUN);
    end

    // Next state: RUN until the last digit, one DONE cycle, start accepted from IDLE or DONE
    always_comb begin
        w_next = r_state;
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Operand latch on accept, then one digit of the result per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_brw <= bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_diff[int'(r_cnt) * DIGIT +: DIGIT] <= w_d;
            r_brw <= w_brw;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_bout <= w_brw;
                r_ovf  <= w_brw ^ w_msb_brw;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_sub_n.sv
// tb_serial_sub_n: table vectors, handshake corner cases and random checks over four configurations
module tb_serial_sub_n;
    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        int          t;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    localparam int NN[4] = '{4, 16, 1, 4};
    localparam int WD[4] = '{16, 16, 16, 8};

    logic        clk;
    logic        rst_n;
    logic        st[4];
    logic [15:0] av[4];
    logic [15:0] bv[4];
    logic        bi[4];
    logic        bs[4];
    logic        dn[4];
    logic [15:0] df[3];
    logic [7:0]  d8;
    logic        bo[4];
    logic        ov[4];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    res_t        sb[4][$];
    vec_t        tbl[12];

    serial_sub_n #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .bin(bi[0]),
        .busy(bs[0]), .done(dn[0]), .diff(df[0]), .bout(bo[0]), .ovf(ov[0]));
    serial_sub_n #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]), .bin(bi[1]),
        .busy(bs[1]), .done(dn[1]), .diff(df[1]), .bout(bo[1]), .ovf(ov[1]));
    serial_sub_n #(.WIDTH(16), .DIGIT(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]), .bin(bi[2]),
        .busy(bs[2]), .done(dn[2]), .diff(df[2]), .bout(bo[2]), .ovf(ov[2]));
    serial_sub_n #(.WIDTH(8), .DIGIT(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .a(av[3][7:0]), .b(bv[3][7:0]), .bin(bi[3]),
        .busy(bs[3]), .done(dn[3]), .diff(d8), .bout(bo[3]), .ovf(ov[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
        res_t   r;
        longint m, ua, ub, xa, xb, s;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        s  = ua - ub - longint'(bin);
        r.diff = 16'(s & (m - 1));
        r.bout = (s < 0);
        xa = (ua >= m / 2) ? ua - m : ua;
        xb = (ub >= m / 2) ? ub - m : ub;
        s  = xa - xb - longint'(bin);
        r.ovf = (s < -(m / 2)) || (s >= m / 2);
        r.t = 0;
        return r;
    endfunction

    function automatic logic [15:0] dval(input int k);
        return (k == 3) ? {8'h00, d8} : df[k];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, need %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int k);
        res_t e;
        logic [15:0] d;
        d = dval(k);
        if (dn[k]) begin
            n_cmp++;
            if (sb[k].size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done inst%0d at cycle %0d", k, cyc);
            end else begin
                e = sb[k].pop_front();
                if (d !== e.diff || bo[k] !== e.bout || ov[k] !== e.ovf || bs[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL result inst%0d: got diff=%h bout=%b ovf=%b busy=%b, need diff=%h bout=%b ovf=%b busy=0",
                             k, d, bo[k], ov[k], bs[k], e.diff, e.bout, e.ovf);
                end
                n_cmp++;
                if (cyc != e.t) begin
                    n_bad++;
                    $display("FAIL latency inst%0d: done at cycle %0d, need %0d", k, cyc, e.t);
                end
            end
        end
    endtask

    // Scoreboard pop on the falling edge, away from the active edge
    always @(negedge clk) for (int k = 0; k < 4; k++) mon(k);

    task automatic push_cur(input int k);
        res_t r;
        r = model(WD[k], av[k], bv[k], bi[k]);
        r.t = cyc + NN[k];
        sb[k].push_back(r);
    endtask

    task automatic wait_empty();
        int i;
        i = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done not seen within 60 cycles");
            for (int k = 0; k < 4; k++) sb[k].delete();
        end
    endtask

    task automatic go(input vec_t v);
        res_t e;
        st[0] = 1'b1;
        av[0] = v.a;
        bv[0] = v.b;
        bi[0] = v.bin;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        e = '{v.diff, v.bout, v.ovf, cyc + NN[0]};
        sb[0].push_back(e);
        chk("busy_after_accept", {31'd0, bs[0]}, 32'd1);
    endtask

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st[k] = 1'b0;
            av[k] = '0;
            bv[k] = '0;
            bi[k] = 1'b0;
        end
        tbl[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2]  = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[5]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6]  = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[7]  = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h7FFE, 1'b0, 1'b0};
        tbl[10] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[11] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h0E1D, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("reset_inst%0d", k), {12'd0, bs[k], dn[k], bo[k], ov[k], dval(k)}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            go(tbl[i]);
            wait_empty();
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("hold_%0d", i), {13'd0, dn[0], bo[0], ov[0], df[0]}, {14'd0, tbl[i].bout, tbl[i].ovf, tbl[i].diff});
        end

        go(tbl[0]);
        @(posedge clk);
        #1;
        st[0] = 1'b1;
        av[0] = 16'hFFFF;
        bv[0] = 16'h0000;
        bi[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        st[0] = 1'b0;
        wait_empty();

        st[0] = 1'b1;
        av[0] = 16'h1111; bv[0] = 16'h0222; bi[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            push_cur(0);
            if (j == 0) begin av[0] = 16'h5555; bv[0] = 16'h5556; bi[0] = 1'b0; end
            else if (j == 1) begin av[0] = 16'h0100; bv[0] = 16'h0001; bi[0] = 1'b1; end
            else st[0] = 1'b0;
            repeat (NN[0]) @(posedge clk);
        end
        #1;
        wait_empty();

        go(tbl[4]);
        wait_empty();
        go('{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_abort", {31'd0, bs[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {12'd0, bs[0], dn[0], bo[0], ov[0], df[0]}, 32'd0);
        sb[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_abort", {31'd0, dn[0]}, 32'd0);
        go(tbl[11]);
        wait_empty();

        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 4; k++) begin
                st[k] = 1'b1;
                av[k] = 16'($urandom_range(0, 65535)) & ((k == 3) ? 16'h00FF : 16'hFFFF);
                bv[k] = 16'($urandom_range(0, 65535)) & ((k == 3) ? 16'h00FF : 16'hFFFF);
                bi[k] = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                push_cur(k);
                st[k] = 1'b0;
            end
            wait_empty();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
